// File: rtl/dj8_bus_arbiter.sv
// dj8_bus_arbiter
//   Shares the DJ8 memory bus between the CPU and one secondary master (DMA or program
//   loader). The arbiter owns the memory-side address/data/write-strobe mux, pauses the
//   CPU through a registered clock enable and sequences DMA read and write beats.
//
//   Optional feature (compile-time macro DJ8_ARB_GUARD_EN): after each release the CPU is
//   guaranteed MIN_CPU_CYC cycles of bus ownership before the next grant.
//
// Parameters
//   MAX_BURST    max DMA beats per grant, then the grant is forcibly released
//   MIN_CPU_CYC  CPU cycles guaranteed between grants (DJ8_ARB_GUARD_EN only)
//
// Ports
//   clk, reset       clock; asynchronous active-high reset
//   cpu_addr/dout    CPU address and write data
//   cpu_we_n         CPU write enable (active low)
//   cpu_write_cycle  CPU is in a write execute/writeback cycle
//   cpu_din          CPU read data (= mem_rdata, combinational)
//   cpu_clk_en       registered CPU clock enable
//   dma_req/gnt      bus request / registered grant
//   dma_valid/wr     beat request (sampled in DMA idle only) and its direction
//   dma_addr/wdata   beat address and write data
//   dma_ready        one-cycle beat-complete pulse
//   dma_rdata        registered read data, valid with dma_ready on a read beat
//   mem_addr/wdata   memory address and write data
//   mem_we_n         memory write strobe (active low)
//   mem_rdata        memory read data (combinational from mem_addr)
module dj8_bus_arbiter #(
  parameter int unsigned MAX_BURST   = 16,
  parameter int unsigned MIN_CPU_CYC = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_we_n,
  input  logic        cpu_write_cycle,
  output logic [7:0]  cpu_din,
  output logic        cpu_clk_en,
  input  logic        dma_req,
  output logic        dma_gnt,
  input  logic        dma_valid,
  input  logic        dma_wr,
  input  logic [15:0] dma_addr,
  input  logic [7:0]  dma_wdata,
  output logic        dma_ready,
  output logic [7:0]  dma_rdata,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we_n,
  input  logic [7:0]  mem_rdata
);

  localparam int unsigned CntW = $clog2(MAX_BURST + 1);

  typedef enum logic [2:0] {
    StCpu,
    StPause,
    StDmaIdle,
    StRead,
    StSetup,
    StStrobe,
    StHold,
    StRelease
  } state_e;

  state_e            state_q, state_d;
  logic              clk_en_q, clk_en_d;
  logic              gnt_q, gnt_d;
  logic              ready_q, ready_d;
  logic [7:0]        rdata_q, rdata_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [15:0]       addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              strobe_q, strobe_d;
  logic              guard_ok;
  logic              cpu_bus;

`ifdef DJ8_ARB_GUARD_EN
  // +2 keeps the width at least 1 even for MIN_CPU_CYC = 0.
  localparam int unsigned GuardW = $clog2(MIN_CPU_CYC + 2);

  logic [GuardW-1:0] guard_q, guard_d;

  always_comb begin
    guard_d = guard_q;
    if (state_q == StRelease) begin
      guard_d = GuardW'(MIN_CPU_CYC);
    end else if ((state_q == StCpu) && (guard_q != '0)) begin
      guard_d = guard_q - GuardW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      guard_q <= '0;
    end else begin
      guard_q <= guard_d;
    end
  end

  assign guard_ok = (guard_q == '0);
`else
  assign guard_ok = 1'b1;
`endif

  always_comb begin
    state_d  = state_q;
    clk_en_d = clk_en_q;
    gnt_d    = gnt_q;
    ready_d  = 1'b0;
    rdata_d  = rdata_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    unique case (state_q)
      StCpu: begin
        // Only pause on a non-write cycle so a CPU write is never split.
        if (dma_req && !cpu_write_cycle && cpu_we_n && guard_ok) begin
          state_d  = StPause;
          clk_en_d = 1'b0;
        end
      end
      StPause: begin
        // The CPU took one more edge; if that moved it into a write, hand the bus back.
        if (cpu_write_cycle || !cpu_we_n) begin
          state_d  = StCpu;
          clk_en_d = 1'b1;
        end else begin
          state_d = StDmaIdle;
          gnt_d   = 1'b1;
        end
      end
      StDmaIdle: begin
        if (!dma_req || (cnt_q == CntW'(MAX_BURST))) begin
          state_d = StRelease;
          gnt_d   = 1'b0;
        end else if (dma_valid) begin
          addr_d  = dma_addr;
          wdata_d = dma_wdata;
          cnt_d   = cnt_q + CntW'(1);
          state_d = dma_wr ? StSetup : StRead;
        end
      end
      StRead: begin
        rdata_d = mem_rdata;
        ready_d = 1'b1;
        state_d = StDmaIdle;
      end
      StSetup: begin
        state_d = StStrobe;
      end
      StStrobe: begin
        // Ready is registered, so raising it here makes it visible during HOLD.
        ready_d = 1'b1;
        state_d = StHold;
      end
      StHold: begin
        state_d = StDmaIdle;
      end
      StRelease: begin
        cnt_d    = '0;
        clk_en_d = 1'b1;
        state_d  = StCpu;
      end
      default: begin
        state_d = StCpu;
      end
    endcase
    // Registered strobe: low only for the single STROBE cycle.
    strobe_d = (state_d != StStrobe);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StCpu;
      clk_en_q <= 1'b1;
      gnt_q    <= 1'b0;
      ready_q  <= 1'b0;
      rdata_q  <= '0;
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      strobe_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      clk_en_q <= clk_en_d;
      gnt_q    <= gnt_d;
      ready_q  <= ready_d;
      rdata_q  <= rdata_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      strobe_q <= strobe_d;
    end
  end

  assign cpu_bus = (state_q == StCpu) || (state_q == StPause);

  always_comb begin
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    mem_we_n  = strobe_q;
    if (cpu_bus) begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_dout;
      mem_we_n  = cpu_we_n;
    end
  end

  assign cpu_din    = mem_rdata;
  assign cpu_clk_en = clk_en_q;
  assign dma_gnt    = gnt_q;
  assign dma_ready  = ready_q;
  assign dma_rdata  = rdata_q;

endmodule
